a25_wb_serializer: RTL
======================

A25_WB_SERIALIZER -- requirements
Module: a25_wb_serializer

Interface
REQ-001 SHALL have one clock and one reset: clock i_clk; reset i_rst_n, asynchronous, active-low.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  request from port buffer
- o_accepted  out  1  request taken this cycle
- i_write  in  1  1=write, 0=read
- i_wdata  in  128  write line
- i_be  in  16  byte enables
- i_addr  in  32  byte address; bits [3:0] ignored
- o_rdata  out  128  assembled read line
- o_rdata_valid  out  1  read line complete pulse
- o_wb_adr  out  32  wishbone address
- o_wb_sel  out  4  wishbone byte select
- o_wb_we  out  1  wishbone write enable
- o_wb_dat  out  32  wishbone write data
- o_wb_cyc  out  1  wishbone cycle
- o_wb_stb  out  1  wishbone strobe
- i_wb_dat  in  32  wishbone read data
- i_wb_ack  in  1  wishbone acknowledge

Function
REQ-003 SHALL implement states IDLE, BUS, RDONE.
REQ-004 o_accepted SHALL equal i_valid AND (state==IDLE), combinationally, with no registered delay.
REQ-005 On accept, SHALL latch i_write, i_wdata, i_be, i_addr[31:4].
REQ-006 Beat k (0..3) SHALL map to word k: address {addr[31:4], k[1:0], 2'b00}; data bits [32k+31:32k]; enables be[4k+3:4k].
REQ-007 Read: SHALL issue all four beats in order k=0..3, each with o_wb_sel=4'hf and o_wb_we=0.
REQ-008 Write: SHALL issue only beats whose enable nibble is nonzero, in ascending k; o_wb_sel = that nibble; o_wb_we=1.
REQ-009 A write with i_be==16'h0 SHALL be accepted, SHALL produce no bus activity, and SHALL leave the state at IDLE.
REQ-010 IDLE->BUS on accept of a read, or of a write with nonzero be; o_wb_cyc=o_wb_stb=1 from the next cycle.
REQ-011 In BUS: o_wb_adr/sel/we/dat SHALL be registered and stable while stb=1 and ack=0; cyc and stb SHALL stay high across all beats of one request.
REQ-012 On i_wb_ack in BUS, SHALL advance to the next enabled beat on the following cycle.
REQ-013 On i_wb_ack for a read beat k, SHALL capture i_wb_dat into o_rdata word k.
REQ-014 On ack of the last beat, SHALL deassert cyc and stb on the next cycle.
REQ-015 After the last beat of a write, SHALL go to IDLE; after the last beat of a read, SHALL go to RDONE.
REQ-016 In RDONE, o_rdata_valid=1 for exactly one cycle, then IDLE; no other state asserts o_rdata_valid.
REQ-017 o_rdata SHALL hold its value until a subsequent read beat is captured.
REQ-018 i_wb_ack while cyc=0 SHALL be ignored.
REQ-019 The minimum request period SHALL be: read 4 acks + 2 cycles; write of n beats n acks + 1 cycle, with zero wait states.

Reset
REQ-020 On i_rst_n low: state=IDLE; o_wb_cyc, o_wb_stb and o_wb_we = 0; o_wb_adr, o_wb_sel, o_wb_dat and o_rdata = 0; o_rdata_valid=0.
REQ-021 Reset asserted mid-burst SHALL drop cyc/stb immediately (asynchronously); the in-flight request is discarded and no o_rdata_valid is produced.
REQ-022 o_accepted SHALL be 0 while reset is asserted.

Verification
REQ-023 Read, addr 32'h0000_1234, ack every cycle -> adr 1230, 1234, 1238, 123C; sel f; rdata words = acked data; o_rdata_valid one pulse 1 cycle after the 4th ack.
REQ-024 Write, be 16'h0F00, wdata word2=32'hDEADBEEF, addr 32'h100 -> single beat, adr 32'h108, sel f, dat DEADBEEF, we 1; IDLE 1 cycle after ack.
REQ-025 Write, be 16'hA0_05 -> beats k=0 (sel 5) and k=3 (sel A) only; cyc held high between the two beats.
REQ-026 Write, be 16'h0000 -> o_accepted=1, cyc never asserts; next i_valid is accepted on the following cycle.
REQ-027 Read with 3 wait states per beat -> adr/sel stable during the waits; exactly 4 captures.
REQ-028 Reset pulsed after the 2nd read ack -> cyc=0 during reset; no rdata_valid; a new request after reset completes normally.

Source files
------------

// File: rtl/a25_wb_serializer.sv
// rtl/a25_wb_serializer.sv - splits 128-bit line requests into 32-bit wishbone beats
module a25_wb_serializer (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_accepted,
    input  logic         i_write,
    input  logic [127:0] i_wdata,
    input  logic [15:0]  i_be,
    input  logic [31:0]  i_addr,
    output logic [127:0] o_rdata,
    output logic         o_rdata_valid,
    output logic [31:0]  o_wb_adr,
    output logic [3:0]   o_wb_sel,
    output logic         o_wb_we,
    output logic [31:0]  o_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic [31:0]  i_wb_dat,
    input  logic         i_wb_ack
);

    typedef enum logic [1:0] {IDLE, BUS, RDONE} state_t;

    state_t         state_q, state_d;
    logic           write_q, write_d;
    logic [127:0]   wdata_q, wdata_d;
    logic [15:0]    be_q, be_d;
    logic [27:0]    addr_q, addr_d;
    logic [1:0]     beat_q, beat_d;
    logic [31:0]    wb_adr_q, wb_adr_d;
    logic [3:0]     wb_sel_q, wb_sel_d;
    logic           wb_we_q, wb_we_d;
    logic [31:0]    wb_dat_q, wb_dat_d;
    logic           cyc_q, cyc_d;
    logic [127:0]   rdata_q, rdata_d;

    logic           accept;
    logic           ld_write;
    logic [127:0]   ld_wdata;
    logic [15:0]    ld_be;
    logic [27:0]    ld_addr;
    logic [2:0]     ld_start;
    logic [2:0]     hit;
    logic           addr_unused;

    assign addr_unused = &{1'b0, i_addr[3:0]};

    // Lowest enabled beat at or above start; bit 2 flags that one exists.
    function automatic logic [2:0] first_beat(input logic [15:0] be, input logic [2:0] start);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            if ((3'(k) >= start) && (be[4*k +: 4] != 4'h0)) begin
                r = {1'b1, 2'(k)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            wb_adr_q <= '0;
            wb_sel_q <= '0;
            wb_we_q  <= 1'b0;
            wb_dat_q <= '0;
            cyc_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            wb_adr_q <= wb_adr_d;
            wb_sel_q <= wb_sel_d;
            wb_we_q  <= wb_we_d;
            wb_dat_q <= wb_dat_d;
            cyc_q    <= cyc_d;
            rdata_q  <= rdata_d;
        end
    end

    // Beat selection reads the live request in IDLE and the latched copy in BUS.
    // Reads use an all-ones enable mask so every beat is issued with sel=f.
    always_comb begin
        accept   = i_valid && (state_q == IDLE) && i_rst_n;
        ld_write = (state_q == IDLE) ? i_write : write_q;
        ld_wdata = (state_q == IDLE) ? i_wdata : wdata_q;
        ld_be    = (state_q == IDLE) ? (i_write ? i_be : 16'hffff) : be_q;
        ld_addr  = (state_q == IDLE) ? i_addr[31:4] : addr_q;
        ld_start = (state_q == IDLE) ? 3'd0 : ({1'b0, beat_q} + 3'd1);
        hit      = first_beat(ld_be, ld_start);

        state_d  = state_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        wb_adr_d = wb_adr_q;
        wb_sel_d = wb_sel_q;
        wb_we_d  = wb_we_q;
        wb_dat_d = wb_dat_q;
        cyc_d    = cyc_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = ld_write;
                    wdata_d = ld_wdata;
                    be_d    = ld_be;
                    addr_d  = ld_addr;
                    if (hit[2]) begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    if (!write_q) begin
                        rdata_d[{beat_q, 5'b0} +: 32] = i_wb_dat;
                    end
                    if (!hit[2]) begin
                        cyc_d   = 1'b0;
                        state_d = write_q ? IDLE : RDONE;
                    end
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        if (hit[2] && ((state_q == IDLE && accept) || (state_q == BUS && i_wb_ack))) begin
            beat_d   = hit[1:0];
            wb_adr_d = {ld_addr, hit[1:0], 2'b00};
            wb_sel_d = ld_be[{hit[1:0], 2'b00} +: 4];
            wb_we_d  = ld_write;
            wb_dat_d = ld_write ? ld_wdata[{hit[1:0], 5'b0} +: 32] : 32'h0;
        end
    end

    assign o_accepted    = accept;
    assign o_rdata       = rdata_q;
    assign o_rdata_valid = (state_q == RDONE);
    assign o_wb_adr      = wb_adr_q;
    assign o_wb_sel      = wb_sel_q;
    assign o_wb_we       = wb_we_q;
    assign o_wb_dat      = wb_dat_q;
    assign o_wb_cyc      = cyc_q;
    assign o_wb_stb      = cyc_q;

endmodule
